// File: rtl/traffic_sequencer.sv
// ----------------------------------------------------------------------------
// traffic_sequencer
//
// Four-way intersection lamp sequencer with a pedestrian walk phase and a
// flashing-yellow night mode. Every state runs for a fixed number of seconds,
// which an external seconds-timer measures. On the first cycle of each state
// the sequencer clears that timer and loads the state's duration into it. It
// then waits for the timer's done flag before it moves to the next state.
//
// Ports
//   CLK         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low
//   enable      in   1   1 = run, 0 = freeze state and pause the timer
//   ped_req     in   1   pedestrian button (level, latched as a pending request)
//   night_mode  in   1   request flashing-yellow operation
//   timer_done  in   1   seconds-timer finished flag
//   timer_en    out  1   seconds-timer enable
//   timer_clr   out  1   seconds-timer clear, one pulse per state entry
//   timer_secs  out  16  duration of the current state
//   ns_light    out  3   north-south lamps {R,Y,G}
//   ew_light    out  3   east-west lamps {R,Y,G}
//   walk        out  1   pedestrian walk lamp
//   state       out  3   current state code
// ----------------------------------------------------------------------------
module traffic_sequencer #(
    parameter logic [15:0] T_GREEN  = 16'd20,
    parameter logic [15:0] T_YELLOW = 16'd3,
    parameter logic [15:0] T_ALLRED = 16'd1,
    parameter logic [15:0] T_WALK   = 16'd10
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        ped_req,
    input  logic        night_mode,
    input  logic        timer_done,
    output logic        timer_en,
    output logic        timer_clr,
    output logic [15:0] timer_secs,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic        walk,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED2  = 3'd5,
        PED_WALK  = 3'd6,
        NIGHT     = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    state_t state_q, state_d;
    logic   entry_q, entry_d;
    logic   started_q, started_d;
    logic   ped_pending_q, ped_pending_d;
    logic   flash_q, flash_d;
    logic   advance;

    // State register. Reset leaves started_q low so that the first edge after
    // release makes the cycle that follows an ALL_RED2 entry cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q       <= ALL_RED2;
            entry_q       <= 1'b0;
            started_q     <= 1'b0;
            ped_pending_q <= 1'b0;
            flash_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            started_q     <= started_d;
            ped_pending_q <= ped_pending_d;
            flash_q       <= flash_d;
        end
    end

    // Next-state logic. The sequencer ignores timer_done on an entry cycle
    // because the timer has not been cleared yet at that point. A NIGHT state
    // that stays in NIGHT counts as a re-entry. That re-entry restarts the
    // one-second flash period.
    always_comb begin
        state_d       = state_q;
        entry_d       = 1'b0;
        started_d     = 1'b1;
        flash_d       = flash_q;
        ped_pending_d = ped_pending_q | ped_req;
        advance       = started_q && !entry_q && enable && timer_done;

        if (!started_q) begin
            entry_d = 1'b1;
        end else if (advance) begin
            entry_d = 1'b1;
            case (state_q)
                NS_GREEN:  state_d = NS_YELLOW;
                NS_YELLOW: state_d = ALL_RED1;
                ALL_RED1:  state_d = night_mode ? NIGHT : EW_GREEN;
                EW_GREEN:  state_d = EW_YELLOW;
                EW_YELLOW: state_d = ALL_RED2;
                ALL_RED2: begin
                    if (night_mode) begin
                        state_d = NIGHT;
                    end else if (ped_pending_q) begin
                        state_d = PED_WALK;
                    end else begin
                        state_d = NS_GREEN;
                    end
                end
                PED_WALK:  state_d = NS_GREEN;
                NIGHT: begin
                    if (night_mode) begin
                        flash_d = ~flash_q;
                    end else begin
                        state_d = ALL_RED2;
                        flash_d = 1'b0;
                    end
                end
                default:   state_d = ALL_RED2;
            endcase
            // Entering the walk phase serves the request. This clear takes
            // priority over a button press in the same cycle.
            if (state_d == PED_WALK) begin
                ped_pending_d = 1'b0;
            end
        end
    end

    // Timer handshake, duration and lamp decode, all from registered state.
    always_comb begin
        timer_clr = entry_q;
        timer_en  = entry_q || (started_q && enable);
        state     = state_q;
        walk      = 1'b0;
        ns_light  = LAMP_RED;
        ew_light  = LAMP_RED;

        case (state_q)
            NS_GREEN, EW_GREEN:   timer_secs = T_GREEN;
            NS_YELLOW, EW_YELLOW: timer_secs = T_YELLOW;
            ALL_RED1, ALL_RED2:   timer_secs = T_ALLRED;
            PED_WALK:             timer_secs = T_WALK;
            default:              timer_secs = 16'd1;
        endcase

        case (state_q)
            NS_GREEN:  ns_light = LAMP_GREEN;
            NS_YELLOW: ns_light = LAMP_YELLOW;
            EW_GREEN:  ew_light = LAMP_GREEN;
            EW_YELLOW: ew_light = LAMP_YELLOW;
            PED_WALK:  walk     = 1'b1;
            NIGHT: begin
                ns_light = flash_q ? LAMP_YELLOW : LAMP_OFF;
                ew_light = flash_q ? LAMP_YELLOW : LAMP_OFF;
            end
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// ----------------------------------------------------------------------------
// tb_traffic_sequencer
//
// Runs the sequencer in lockstep with a reference model that is written from
// the intersection rules: state codes, per-state durations and lamp patterns.
// A simple seconds-timer model can stand in for the real timer and generate
// timer_done. Otherwise timer_done is driven at random.
// ----------------------------------------------------------------------------
module tb_traffic_sequencer;

   localparam logic [15:0] TG = 16'd3;
   localparam logic [15:0] TY = 16'd2;
   localparam logic [15:0] TA = 16'd1;
   localparam logic [15:0] TW = 16'd2;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        ped_req = 1'b0;
   logic        night_mode = 1'b0;
   logic        timer_done = 1'b0;
   logic        timer_en;
   logic        timer_clr;
   logic [15:0] timer_secs;
   logic [2:0]  ns_light;
   logic [2:0]  ew_light;
   logic        walk;
   logic [2:0]  state;

   traffic_sequencer #(
      .T_GREEN (TG),
      .T_YELLOW(TY),
      .T_ALLRED(TA),
      .T_WALK  (TW)
   ) dut (
      .CLK       (CLK),
      .reset     (reset),
      .enable    (enable),
      .ped_req   (ped_req),
      .night_mode(night_mode),
      .timer_done(timer_done),
      .timer_en  (timer_en),
      .timer_clr (timer_clr),
      .timer_secs(timer_secs),
      .ns_light  (ns_light),
      .ew_light  (ew_light),
      .walk      (walk),
      .state     (state)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   // reference model: current state code, first-cycle flag, started flag,
   // pending pedestrian request and night flash phase
   int mState;
   bit mEntry;
   bit mStarted;
   bit mPend;
   bit mFlash;

   bit useTimer = 1'b0;
   int tCnt = 0;
   int prevState = 5;
   int runLen = 1;
   int lastObs = 5;
   logic lastTen = 1'b0;
   int seen[$];

   // duration of each state code, in timer seconds
   function automatic logic [15:0] durOf(input int s);
      case (s)
         0, 3:    return TG;
         1, 4:    return TY;
         2, 5:    return TA;
         6:       return TW;
         default: return 16'd1;
      endcase
   endfunction

   // lamps for each state code as {ns, ew, walk}; red=100 yellow=010 green=001
   function automatic logic [6:0] lampsOf(input int s, input bit f);
      case (s)
         0:       return {3'b001, 3'b100, 1'b0};
         1:       return {3'b010, 3'b100, 1'b0};
         3:       return {3'b100, 3'b001, 1'b0};
         4:       return {3'b100, 3'b010, 1'b0};
         6:       return {3'b100, 3'b100, 1'b1};
         7:       return f ? {3'b010, 3'b010, 1'b0} : {3'b000, 3'b000, 1'b0};
         default: return {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   // single comparison point: counts and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // compare every DUT output against the model's view of the current cycle
   task automatic checkAll();
      logic [6:0] lamps;
      lamps = lampsOf(mState, mFlash);
      checkOutput("state", 32'(state), 32'(mState));
      checkOutput("ns_light", 32'(ns_light), 32'(lamps[6:4]));
      checkOutput("ew_light", 32'(ew_light), 32'(lamps[3:1]));
      checkOutput("walk", 32'(walk), 32'(lamps[0]));
      checkOutput("timer_clr", 32'(timer_clr), 32'(mEntry));
      checkOutput("timer_en", 32'(timer_en), 32'(mEntry || (mStarted && enable)));
      checkOutput("timer_secs", 32'(timer_secs), 32'(durOf(mState)));
   endtask

   task automatic modelReset();
      mState = 5;
      mEntry = 1'b0;
      mStarted = 1'b0;
      mPend = 1'b0;
      mFlash = 1'b0;
      tCnt = 0;
   endtask

   // one clock edge of the intersection rules, using the sampled inputs
   task automatic modelStep();
      bit pendNext;
      int nxt;
      pendNext = mPend | ped_req;
      if (!mStarted) begin
         mStarted = 1'b1;
         mEntry = 1'b1;
      end else if (!mEntry && enable && timer_done) begin
         nxt = mState;
         if (mState == 2) nxt = night_mode ? 7 : 3;
         else if (mState == 5) nxt = night_mode ? 7 : (mPend ? 6 : 0);
         else if (mState == 6) nxt = 0;
         else if (mState == 7) begin
            if (night_mode) mFlash = !mFlash;
            else begin
               nxt = 5;
               mFlash = 1'b0;
            end
         end else nxt = mState + 1;
         if (nxt == 6) pendNext = 1'b0;
         mState = nxt;
         mEntry = 1'b1;
      end else begin
         mEntry = 1'b0;
      end
      mPend = pendNext;
   endtask

   // one full clock: check at the falling edge, then advance the model and
   // the timer model on the rising edge
   task automatic applyStimulus();
      @(negedge CLK);
      checkAll();
      lastObs = int'(state);
      lastTen = timer_en;
      if (lastObs != prevState) begin
         checkOutput("dwell_ge2", 32'(runLen >= 2), 32'd1);
         seen.push_back(lastObs);
         prevState = lastObs;
         runLen = 1;
      end else begin
         runLen++;
      end
      if (useTimer) timer_done = (tCnt >= int'(durOf(mState)));
      @(posedge CLK);
      if (reset) begin
         if (mEntry) tCnt = 0;
         else if (mStarted && enable) tCnt++;
         modelStep();
      end
      #1;
   endtask

   task automatic runUntil(input int target, input int maxCycles);
      int n;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (lastObs != target && n < maxCycles);
      checkOutput("reach_state", 32'(lastObs), 32'(target));
   endtask

   int expSeq[8] = '{5, 0, 1, 2, 3, 4, 5, 0};

   initial begin
      modelReset();

      // reset state held over a few edges
      repeat (3) applyStimulus();

      // normal cycle from reset release, driven by the timer model
      reset = 1'b1;
      enable = 1'b1;
      useTimer = 1'b1;
      seen.delete();
      seen.push_back(5);
      for (int i = 0; i < 200 && seen.size() < 8; i++) applyStimulus();
      for (int i = 0; i < 8; i++) begin
         checkOutput("seq", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF, 32'(expSeq[i]));
      end

      // pedestrian pulse during EW_GREEN is served after ALL_RED2, then cleared
      runUntil(3, 200);
      ped_req = 1'b1;
      applyStimulus();
      ped_req = 1'b0;
      runUntil(6, 200);
      checkOutput("ped_walk_lamp", 32'(walk), 32'd1);
      checkOutput("ped_walk_secs", 32'(timer_secs), 32'(TW));
      runUntil(0, 50);
      runUntil(5, 200);
      for (int i = 0; i < 20 && lastObs == 5; i++) applyStimulus();
      checkOutput("ped_cleared", 32'(lastObs), 32'd0);

      // night request during green is deferred to the next all-red exit
      night_mode = 1'b1;
      runUntil(7, 200);
      repeat (12) applyStimulus();
      night_mode = 1'b0;
      runUntil(5, 20);
      runUntil(0, 50);

      // done flag stuck high: one step per state, never a double jump
      useTimer = 1'b0;
      timer_done = 1'b1;
      repeat (40) applyStimulus();

      // freeze while EW_YELLOW has done asserted, then resume
      useTimer = 1'b1;
      runUntil(4, 200);
      useTimer = 1'b0;
      enable = 1'b0;
      timer_done = 1'b1;
      for (int i = 0; i < 50; i++) begin
         applyStimulus();
         checkOutput("freeze_state", 32'(lastObs), 32'd4);
         checkOutput("freeze_ten", 32'(lastTen), 32'd0);
      end
      enable = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("resume_state", 32'(lastObs), 32'd5);

      // randomized operation against the model
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) useTimer = ($urandom_range(0, 1) == 1);
         enable = ($urandom_range(0, 9) != 0);
         ped_req = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 59) == 0) night_mode = ~night_mode;
         if (!useTimer) timer_done = ($urandom_range(0, 2) == 0);
         applyStimulus();
      end

      // asynchronous reset in the middle of PED_WALK with a fresh request
      enable = 1'b1;
      night_mode = 1'b0;
      useTimer = 1'b1;
      ped_req = 1'b1;
      applyStimulus();
      ped_req = 1'b0;
      runUntil(6, 200);
      ped_req = 1'b1;
      applyStimulus();
      ped_req = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkAll();
      checkOutput("async_state", 32'(state), 32'd5);
      prevState = 5;
      runLen = 1;
      repeat (3) applyStimulus();
      reset = 1'b1;
      seen.delete();
      repeat (30) applyStimulus();
      checkOutput("no_stale_ped", (seen.size() > 0) ? 32'(seen[0]) : 32'hFFFF, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
